// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift-link controller and its arbiter.
package shift_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic MODE_PISO = 1'b0;
  localparam logic MODE_SIPO = 1'b1;

  typedef enum logic {
    OWN_TX = 1'b0,
    OWN_RX = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (TX vs RX) remembering the last owner.
module rr_arb2
  import shift_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req_tx_i,
  input  logic req_rx_i,
  input  logic update_i,
  output logic tx_open_o,
  output logic gnt_tx_o,
  output logic gnt_rx_o
);

  owner_e last_q, last_d;

  // TX may go unless RX is also asking and TX had the previous turn.
  assign tx_open_o = en_i && (!req_rx_i || (last_q == OWN_RX));
  assign gnt_tx_o  = tx_open_o && req_tx_i;
  assign gnt_rx_o  = en_i && req_rx_i && !gnt_tx_o;

  always_comb begin
    last_d = last_q;
    if (update_i && gnt_tx_o) begin
      last_d = OWN_TX;
    end else if (update_i && gnt_rx_o) begin
      last_d = OWN_RX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_RX;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/shift_link_controller.sv
// Shared-shifter controller: grants the shifter to TX (PISO) or RX (SIPO),
// sequences load/wait/shift/done and holds one captured RX word.
module shift_link_controller
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int START_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             tx_done,
  input  logic             rx_req,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  input  logic             rx_ready,
  output logic             busy,
  output logic             shf_mode,
  output logic             shf_start,
  output logic [WIDTH-1:0] shf_parallel_in,
  input  logic [WIDTH-1:0] shf_parallel_out
);

  localparam int CNT_MAX = (WIDTH > START_LAT) ? WIDTH : START_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] pin_q, pin_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;

  logic arb_en, rx_cand, tx_open, gnt_tx, gnt_rx;

  // Gating with rst_n keeps tx_ready low while reset is held.
  assign arb_en  = (state_q == ST_IDLE) && rst_n;
  assign rx_cand = rx_req && !rx_valid_q;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (arb_en),
    .req_tx_i  (tx_valid),
    .req_rx_i  (rx_cand),
    .update_i  (arb_en),
    .tx_open_o (tx_open),
    .gnt_tx_o  (gnt_tx),
    .gnt_rx_o  (gnt_rx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    pin_d      = pin_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_tx) begin
          pin_d   = tx_data;
          mode_d  = MODE_PISO;
          state_d = ST_LOAD;
        end else if (gnt_rx) begin
          mode_d  = MODE_SIPO;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = (START_LAT == 0) ? ST_SHIFT : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CW'(START_LAT - 1)) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        // The buffer is known empty here: RX is never granted while it is full.
        if (mode_q == MODE_SIPO) begin
          rx_data_d  = shf_parallel_out;
          rx_valid_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mode_q     <= MODE_PISO;
      pin_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      pin_q      <= pin_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign tx_ready        = tx_open;
  assign tx_done         = (state_q == ST_DONE) && (mode_q == MODE_PISO);
  assign busy            = (state_q != ST_IDLE);
  assign shf_start       = (state_q == ST_LOAD);
  assign shf_mode        = mode_q;
  assign shf_parallel_in = pin_q;
  assign rx_valid        = rx_valid_q;
  assign rx_data         = rx_data_q;

endmodule

// File: tb/tb_shift_link_controller.sv
// Bench for shift_link_controller: cycle-count reference model plus a serial shifter model.
module tb_shift_link_controller;
  import shift_ctrl_pkg::*;

  localparam int W   = 8;
  localparam int SL  = 1;
  localparam int TOT = W + SL + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         tx_valid, rx_req, rx_ready;
  logic [W-1:0] tx_data;
  logic [W-1:0] shf_parallel_out = '0;
  logic         tx_ready, tx_done, rx_valid, busy, shf_mode, shf_start;
  logic [W-1:0] rx_data, shf_parallel_in;

  shift_link_controller #(.WIDTH(W), .START_LAT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_done(tx_done),
    .rx_req(rx_req), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .busy(busy), .shf_mode(shf_mode), .shf_start(shf_start),
    .shf_parallel_in(shf_parallel_in), .shf_parallel_out(shf_parallel_out)
  );

  // Narrow, zero-latency build.
  logic       s_tx_valid, s_rx_req, s_rx_ready;
  logic [3:0] s_tx_data, s_shf_parallel_out;
  logic       s_tx_ready, s_tx_done, s_rx_valid, s_busy, s_shf_mode, s_shf_start;
  logic [3:0] s_rx_data, s_shf_parallel_in;

  shift_link_controller #(.WIDTH(4), .START_LAT(0)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(s_tx_valid), .tx_data(s_tx_data), .tx_ready(s_tx_ready), .tx_done(s_tx_done),
    .rx_req(s_rx_req), .rx_valid(s_rx_valid), .rx_data(s_rx_data), .rx_ready(s_rx_ready),
    .busy(s_busy), .shf_mode(s_shf_mode), .shf_start(s_shf_start),
    .shf_parallel_in(s_shf_parallel_in), .shf_parallel_out(s_shf_parallel_out)
  );

  // Shifter model: SL edges after the start pulse, shifts W bits of serial_word in MSB first.
  logic [W-1:0] serial_word;
  logic [W-1:0] sh_word = '0;
  int           sh_delay = 0;
  int           sh_left  = 0;

  always @(posedge clk) begin
    if (shf_start) begin
      sh_word  <= serial_word;
      sh_delay <= SL - 1;
      sh_left  <= W;
    end else if (sh_left > 0) begin
      if (sh_delay == 0) begin
        shf_parallel_out <= {shf_parallel_out[W-2:0], sh_word[sh_left-1]};
        sh_left          <= sh_left - 1;
      end else begin
        sh_delay <= sh_delay - 1;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: m_cnt = index of the current busy cycle (0 when idle).
  int           m_cnt;
  logic         m_mode, m_last_rx, m_rxv;
  logic [W-1:0] m_pin, m_rxd, m_word;
  bit           gq[$];

  task automatic model_reset();
    m_cnt = 0; m_mode = 1'b0; m_last_rx = 1'b1; m_rxv = 1'b0;
    m_pin = '0; m_rxd = '0; m_word = '0;
  endtask

  task automatic check_zero(input string pfx);
    check_val({pfx, "_busy"},     32'(busy), 32'd0);
    check_val({pfx, "_tx_ready"}, 32'(tx_ready), 32'd0);
    check_val({pfx, "_tx_done"},  32'(tx_done), 32'd0);
    check_val({pfx, "_start"},    32'(shf_start), 32'd0);
    check_val({pfx, "_mode"},     32'(shf_mode), 32'd0);
    check_val({pfx, "_pin"},      32'(shf_parallel_in), 32'd0);
    check_val({pfx, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check_val({pfx, "_rx_data"},  32'(rx_data), 32'd0);
  endtask

  task automatic do_reset();
    tx_valid = 1'b0; tx_data = '0; rx_req = 1'b0; rx_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model over the edge.
  task automatic step(input logic tv, input logic [W-1:0] td, input logic rr,
                      input logic rdy, input logic [W-1:0] sw);
    logic rx_cand, tx_open, tx_acc, rx_gnt;
    @(negedge clk);
    tx_valid = tv; tx_data = td; rx_req = rr; rx_ready = rdy;
    rx_cand = rr && !m_rxv;
    tx_open = (m_cnt == 0) && (!rx_cand || m_last_rx);
    tx_acc  = tx_open && tv;
    rx_gnt  = (m_cnt == 0) && rx_cand && !tx_acc;
    #1;
    check_val("busy",     32'(busy),      32'(m_cnt != 0));
    check_val("start",    32'(shf_start), 32'(m_cnt == 1));
    check_val("tx_done",  32'(tx_done),   32'((m_cnt == TOT) && !m_mode));
    check_val("tx_ready", 32'(tx_ready),  32'(tx_open));
    check_val("rx_valid", 32'(rx_valid),  32'(m_rxv));
    check_val("rx_data",  32'(rx_data),   32'(m_rxd));
    check_val("mode",     32'(shf_mode),  32'(m_mode));
    check_val("pin",      32'(shf_parallel_in), 32'(m_pin));
    if (m_rxv && rdy) m_rxv = 1'b0;
    if (m_cnt == TOT) begin
      if (m_mode) begin m_rxv = 1'b1; m_rxd = m_word; end
      m_cnt = 0;
    end else if (m_cnt != 0) begin
      m_cnt++;
    end else if (tx_acc) begin
      m_cnt = 1; m_mode = MODE_PISO; m_pin = td; m_last_rx = 1'b0; gq.push_back(1'b0);
    end else if (rx_gnt) begin
      m_cnt = 1; m_mode = MODE_SIPO; m_last_rx = 1'b1;
      m_word = sw; serial_word = sw; gq.push_back(1'b1);
    end
  endtask

  initial begin
    int s_busy_n, s_done_at, s_done_n;
    serial_word = '0;
    s_tx_valid = 1'b0; s_tx_data = '0; s_rx_req = 1'b0; s_rx_ready = 1'b0; s_shf_parallel_out = '0;
    model_reset();

    // Reset held, with a request pending: everything must read 0.
    tx_valid = 1'b1; tx_data = 8'hFF; rx_req = 1'b1; rx_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_zero("rst");
    check_val("s_rst_busy", 32'(s_busy), 32'd0);
    check_val("s_rst_pin",  32'(s_shf_parallel_in), 32'd0);
    do_reset();

    // TX 0xCC alone.
    step(1'b1, 8'hCC, 1'b0, 1'b0, '0);
    repeat (TOT + 2) step(1'b0, '0, 1'b0, 1'b0, '0);

    // RX alone, serial 1,0,1,1,0,1,0,1; buffer held until popped.
    step(1'b0, '0, 1'b1, 1'b0, 8'b10110101);
    repeat (TOT + 3) step(1'b0, '0, 1'b0, 1'b0, '0);
    check_val("rx_word", 32'(rx_data), 32'h0000_00B5);
    step(1'b0, '0, 1'b0, 1'b1, '0);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, '0);

    // Reset at the 4th SHIFT cycle of a TX 0x3C transfer.
    step(1'b1, 8'h3C, 1'b0, 1'b0, '0);
    for (int k = 0; k < 20 && m_cnt != 6; k++) step(1'b0, '0, 1'b0, 1'b0, '0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    step(1'b1, 8'h5A, 1'b0, 1'b0, '0);
    repeat (TOT + 1) step(1'b0, '0, 1'b0, 1'b0, '0);

    // Both requesters held from reset, consumer always ready: TX, RX, TX, RX.
    do_reset();
    gq.delete();
    repeat (4 * (TOT + 1) + 2) step(1'b1, W'($urandom), 1'b1, 1'b1, W'($urandom));
    check_val("rr_count", 32'(gq.size() >= 4), 32'd1);
    if (gq.size() >= 4) begin
      check_val("rr_g0", 32'(gq[0]), 32'd0);
      check_val("rr_g1", 32'(gq[1]), 32'd1);
      check_val("rr_g2", 32'(gq[2]), 32'd0);
      check_val("rr_g3", 32'(gq[3]), 32'd1);
    end

    // Full buffer blocks RX; one pop re-enables it in the next idle cycle.
    repeat (3 * TOT) step(1'b0, '0, 1'b1, 1'b0, W'($urandom));
    step(1'b0, '0, 1'b1, 1'b1, W'($urandom));
    repeat (TOT + 3) step(1'b0, '0, 1'b1, 1'b0, W'($urandom));

    // Randomised traffic.
    do_reset();
    repeat (800) step($urandom_range(99) < 35, W'($urandom), $urandom_range(99) < 35,
                      $urandom_range(99) < 50, W'($urandom));

    // WIDTH=4, START_LAT=0 build: TX 0xA.
    @(negedge clk);
    s_tx_valid = 1'b1; s_tx_data = 4'hA;
    #1 check_val("s_tx_ready", 32'(s_tx_ready), 32'd1);
    s_busy_n = 0; s_done_at = 0; s_done_n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      s_tx_valid = 1'b0;
      #1;
      if (s_busy) s_busy_n++;
      if (s_tx_done) begin s_done_n++; s_done_at = c; end
      if (c == 1) begin
        check_val("s_start", 32'(s_shf_start), 32'd1);
        check_val("s_pin",   32'(s_shf_parallel_in), 32'hA);
        check_val("s_mode",  32'(s_shf_mode), 32'd0);
      end
    end
    check_val("s_busy_cycles", 32'(s_busy_n), 32'd6);
    check_val("s_done_cycle",  32'(s_done_at), 32'd6);
    check_val("s_done_pulses", 32'(s_done_n), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_link_controller.md
# shift_link_controller

Sequencing and arbitration controller for the 8-bit serial/parallel shift datapath (the SIPO/PISO transmitter). Two requesters share the one shifter: a transmit port that hands in parallel words for PISO serialisation, and a receive port that requests SIPO capture of a serial word. The block grants the shifter to one requester at a time, drives the shifter's mode select, start pulse and parallel load word, counts shift cycles, and returns captured words through a one-deep output buffer.

## Interface
- `WIDTH`, default 8: shifter word width; also the number of shift cycles per transfer.
- `START_LAT`, default 1: cycles between the shifter's start pulse and its first shift edge.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `tx_valid`  in  1  transmit word available.
- `tx_data`  in  WIDTH  word to serialise.
- `tx_ready`  out  1  transmit grant; the word is accepted on the edge where `tx_valid && tx_ready`.
- `tx_done`  out  1  one-cycle pulse at the end of a transmit transfer.
- `rx_req`  in  1  level request for one receive capture.
- `rx_valid`  out  1  captured word held in the output buffer.
- `rx_data`  out  WIDTH  captured word.
- `rx_ready`  in  1  consumer pops the buffer on the edge where `rx_valid && rx_ready`.
- `busy`  out  1  a transfer is in progress.
- `shf_mode`  out  1  shifter mode: 0 = PISO (TX), 1 = SIPO (RX).
- `shf_start`  out  1  one-cycle start pulse to the shifter.
- `shf_parallel_in`  out  WIDTH  load word for the shifter.
- `shf_parallel_out`  in  WIDTH  shifter parallel output.

## Operation
- FSM states: IDLE, LOAD, WAIT, SHIFT, DONE.
- IDLE: the TX candidate is `tx_valid`. The RX candidate is `rx_req && !rx_valid`; a full buffer blocks RX grants.
- Arbitration is round-robin on ties through a `last_grant` bit. After reset `last_grant` = RX, so TX wins the first tie. A lone candidate always wins.
- TX grant: `tx_ready`=1 in IDLE, combinational. On the accept edge, `shf_parallel_in` <= `tx_data`, `shf_mode` <= 0, `last_grant` <= TX, and the FSM goes to LOAD.
- RX grant: on the same edge type, `shf_mode` <= 1, `last_grant` <= RX, and the FSM goes to LOAD. `shf_parallel_in` is unchanged.
- LOAD: `shf_start`=1 for exactly one cycle, then WAIT.
- WAIT: lasts START_LAT cycles, then SHIFT. When START_LAT=0, LOAD goes straight to SHIFT.
- SHIFT: a bit counter runs 0..WIDTH-1. After WIDTH cycles the FSM goes to DONE.
- DONE, one cycle, then IDLE:
  - TX transfer: `tx_done`=1.
  - RX transfer: `rx_data` <= `shf_parallel_out` and `rx_valid` <= 1 on the exit edge.
- `shf_mode` and `shf_parallel_in` stay constant from the grant edge until the next grant edge.
- `tx_ready` is 0 in every state except IDLE.
- Output buffer: `rx_valid` clears on pop. A pop and a DONE-write on the same edge cannot occur, because no RX grant is made while the buffer is full.
- `rx_req` deasserted after the grant does not abort the transfer. The word is still captured.

## Timing
- Reset, asynchronous: FSM=IDLE, counter=0, `last_grant`=RX. All outputs are 0, including `rx_data` and `shf_parallel_in`.
- Reset asserted mid-transfer aborts immediately. There is no `tx_done`, and any word being captured is discarded.
- Let the accept edge be E0:
  - LOAD occupies the cycle after E0.
  - SHIFT occupies edges E(1+START_LAT) through E(WIDTH+START_LAT).
  - DONE ends at E(WIDTH+START_LAT+2), which returns the FSM to IDLE.
  - `busy` is high for WIDTH+START_LAT+2 cycles: 11 with the defaults.
- The earliest next grant is in the IDLE cycle immediately after return, so there is no dead cycle.
- `rx_valid` rises on the DONE-exit edge. A new RX grant is possible once the buffer is popped.

## Structure
- Shared package `shift_ctrl_pkg` holds:
  - the FSM state enum;
  - `MODE_PISO`=1'b0 and `MODE_SIPO`=1'b1;
  - the grant-owner enum (TX/RX).
- One natural sub-module, `rr_arb2`: two-requester round-robin arbiter with an enable and an update-on-grant input.
- Counter, FSM and output buffer live in the top block.

## Test plan
- Reset mid-SHIFT (TX 0x3C, `rst_n` low at the 4th SHIFT cycle) -> all outputs 0 at once; `tx_done` never pulses; next `tx_valid` is accepted in the first IDLE cycle after release.
- TX 0xCC alone -> `tx_ready` accepted at E0; `shf_mode`=0 and `shf_parallel_in`=0xCC; `shf_start` high only in the cycle after E0; `busy` high 11 cycles; `tx_done` single pulse in the last busy cycle.
- RX alone, shifter model fed serial 1,0,1,1,0,1,0,1 -> `shf_mode`=1; `rx_valid` rises at E11 with `rx_data`=8'b10110101; `rx_valid` holds until a `rx_ready` pop.
- `tx_valid` and `rx_req` held together from reset, buffer popped immediately -> grant order TX, RX, TX, RX; `shf_mode` toggles only on grant edges.
- RX buffer full (`rx_ready`=0) with `rx_req` held and TX idle -> no grant and `busy`=0; after one pop, the RX grant occurs in the next IDLE cycle.
- START_LAT=0 and WIDTH=4 build, TX 0xA -> `busy` high 6 cycles; `tx_done` in the 6th.
